// File: rtl/console_pkg.sv
// Shared types and constants for the text console sequencer.
// Holds the FSM state encoding, control-character codes, printable range
// and the character-RAM address width.
package console_pkg;

  localparam int ADDR_W = 13;

  typedef enum logic [1:0] {
    CLR_SCREEN = 2'd0,
    IDLE       = 2'd1,
    CLR_LINE   = 2'd2
  } state_t;

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_TAB = 8'h09;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Byte-in / character-RAM-out bundle for the text console sequencer.
// Ports: rx_data/rx_valid/rx_ready (byte stream, valid-ready), ascii_address/
// ascii_data/ascii_wr_en (RAM write port), cursor (linear cursor address).
interface text_console_ctrl_if;
  import console_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] ascii_address;
  logic [7:0]        ascii_data;
  logic              ascii_wr_en;
  logic [ADDR_W-1:0] cursor;

  // master: byte source / RAM + display sink side
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, ascii_address, ascii_data, ascii_wr_en, cursor
  );

  // slave: the console sequencer itself
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, ascii_address, ascii_data, ascii_wr_en, cursor
  );

endinterface

// File: rtl/console_cursor.sv
// Text cursor position: col, row and row base address (row*COLS, kept
// incrementally, no multiplier). Registered cursor = line_base + col.
// Ports: inc/dec/cr/home/newline/tab commands (priority home > newline > cr >
// tab > inc > dec); outputs col, row, line_base, at_last_col, cursor.
module console_cursor
  import console_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  input  logic                     dec,
  input  logic                     cr,
  input  logic                     home,
  input  logic                     newline,
  input  logic                     tab,
  output logic [$clog2(COLS)-1:0]  col,
  output logic [$clog2(ROWS)-1:0]  row,
  output logic [ADDR_W-1:0]        line_base,
  output logic                     at_last_col,
  output logic [ADDR_W-1:0]        cursor
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [CW-1:0]     col_n;
  logic [RW-1:0]     row_n;
  logic [ADDR_W-1:0] base_n;

  assign at_last_col = (col == COL_LAST);

  always_comb begin
    col_n  = col;
    row_n  = row;
    base_n = line_base;
    if (home) begin
      col_n  = '0;
      row_n  = '0;
      base_n = '0;
    end else if (newline) begin
      col_n = '0;
      // No scrolling: the last row wraps back to the top of the screen.
      if (row == ROW_LAST) begin
        row_n  = '0;
        base_n = '0;
      end else begin
        row_n  = row + RW'(1);
        base_n = line_base + ADDR_W'(COLS);
      end
    end else if (cr) begin
      col_n = '0;
    end else if (tab) begin
      // Caller only issues tab when the next multiple of 8 is still on the row.
      col_n = {col[CW-1:3] + (CW-3)'(1), 3'b000};
    end else if (inc) begin
      col_n = col + CW'(1);
    end else if (dec) begin
      col_n = col - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      line_base <= '0;
      cursor    <= '0;
    end else begin
      col       <= col_n;
      row       <= row_n;
      line_base <= base_n;
      cursor    <= base_n + ADDR_W'(col_n);
    end
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Byte stream -> character-RAM writes: cursor tracking, control characters,
// line/screen clears one cell per clock. Write registered at the accept edge.
// rx_ready is high only in IDLE; clears hold it low (COLS or COLS*ROWS cycles).
// Ports: clk, rst_n (async active-low), bus (text_console_ctrl_if.slave).
// Optional: CONSOLE_TAB_EN enables 0x09 as tab-to-next-multiple-of-8.
module text_console_ctrl
  import console_pkg::*;
#(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 60,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic               clk,
  input  logic               rst_n,
  text_console_ctrl_if.slave bus
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST   = ADDR_W'(COLS - 1);

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] cnt_q, cnt_n;
  logic              wr_q, wr_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [7:0]        data_q, data_n;

  logic              c_inc, c_dec, c_cr, c_home, c_nl, c_tab;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] line_base;
  logic              at_last_col;
  logic [ADDR_W-1:0] cursor;

`ifdef CONSOLE_TAB_EN
  logic tab_wrap;
  // Next tab stop lands at or past COLS when col/8 + 1 >= ceil(COLS/8).
  assign tab_wrap = ({1'b0, col[CW-1:3]} + (CW-2)'(1)) >= (CW-2)'((COLS + 7) / 8);
`endif

  console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc         (c_inc),
    .dec         (c_dec),
    .cr          (c_cr),
    .home        (c_home),
    .newline     (c_nl),
    .tab         (c_tab),
    .col         (col),
    .row         (row),
    .line_base   (line_base),
    .at_last_col (at_last_col),
    .cursor      (cursor)
  );

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    wr_n    = 1'b0;
    addr_n  = addr_q;
    data_n  = data_q;
    c_inc   = 1'b0;
    c_dec   = 1'b0;
    c_cr    = 1'b0;
    c_home  = 1'b0;
    c_nl    = 1'b0;
    c_tab   = 1'b0;
    unique case (state_q)
      CLR_SCREEN: begin
        wr_n   = 1'b1;
        addr_n = cnt_q;
        data_n = BLANK;
        if (cnt_q == SCREEN_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          c_home  = 1'b1;
        end else begin
          cnt_n = cnt_q + ADDR_W'(1);
        end
      end
      CLR_LINE: begin
        // line_base already points at the freshly entered row.
        wr_n   = 1'b1;
        addr_n = line_base + cnt_q;
        data_n = BLANK;
        if (cnt_q == LINE_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (bus.rx_valid) begin
          if (is_printable(bus.rx_data)) begin
            wr_n   = 1'b1;
            addr_n = line_base + ADDR_W'(col);
            data_n = bus.rx_data;
            if (at_last_col) begin
              c_nl    = 1'b1;
              state_n = CLR_LINE;
            end else begin
              c_inc = 1'b1;
            end
          end else if (bus.rx_data == CH_CR) begin
            c_cr = 1'b1;
          end else if (bus.rx_data == CH_LF) begin
            c_nl    = 1'b1;
            state_n = CLR_LINE;
          end else if (bus.rx_data == CH_BS) begin
            // Backspace never wraps to the previous row.
            if (col != '0) begin
              wr_n   = 1'b1;
              addr_n = line_base + ADDR_W'(col - CW'(1));
              data_n = BLANK;
              c_dec  = 1'b1;
            end
          end else if (bus.rx_data == CH_FF) begin
            state_n = CLR_SCREEN;
`ifdef CONSOLE_TAB_EN
          end else if (bus.rx_data == CH_TAB) begin
            if (tab_wrap) begin
              c_nl    = 1'b1;
              state_n = CLR_LINE;
            end else begin
              c_tab = 1'b1;
            end
`endif
          end
        end
      end
      default: state_n = CLR_SCREEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_SCREEN;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      wr_q    <= wr_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
    end
  end

  assign bus.rx_ready      = (state_q == IDLE);
  assign bus.ascii_wr_en   = wr_q;
  assign bus.ascii_address = addr_q;
  assign bus.ascii_data    = data_q;
  assign bus.cursor        = cursor;

  // Position registers must stay inside the screen.
  a_pos_range: assert property (@(posedge clk) disable iff (!rst_n)
                                (row < RW'(ROWS)) && (col < CW'(COLS)));

endmodule

// File: tb/tb_text_console_ctrl.sv
module tb_text_console_ctrl;
  import console_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  text_console_ctrl_if bus();

  text_console_ctrl #(.COLS(80), .ROWS(60), .BLANK(8'h20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!bus.rx_ready && n < budget) begin
      tick();
      n++;
    end
    if (!bus.rx_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready rx_ready=%0d after %0d cycles, required 1", bus.rx_ready, n);
    end
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready(10000);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // Reset, then the full 4800-cell screen clear from address 0.
  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tick(); tick(); tick();
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %0d want 0", bus.rx_ready); end
    checks++; if (bus.ascii_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0d want 0", bus.ascii_wr_en); end
    checks++; if (bus.ascii_address !== 13'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus.ascii_address); end
    checks++; if (bus.ascii_data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h want 0", bus.ascii_data); end
    checks++; if (bus.cursor !== 13'd0) begin errors++; $display("FAIL reset_cursor got %0d want 0", bus.cursor); end
    rst_n = 1'b1;
    for (int i = 0; i < 4800; i++) begin
      tick();
      if (bus.ascii_wr_en !== 1'b1 || bus.ascii_address !== 13'(i) ||
          bus.ascii_data !== 8'h20 || bus.rx_ready !== (i == 4799)) begin
        if (bad == 0)
          $display("FAIL screen_clear cycle %0d got wr=%0d addr=%0d data=%0h rdy=%0d want wr=1 addr=%0d data=20 rdy=%0d",
                   i, bus.ascii_wr_en, bus.ascii_address, bus.ascii_data, bus.rx_ready, i, (i == 4799));
        bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL screen_clear_bad_cycles got %0d want 0", bad); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL post_clear_ready got %0d want 1", bus.rx_ready); end
    checks++; if (bus.cursor !== 13'd0) begin errors++; $display("FAIL post_clear_cursor got %0d want 0", bus.cursor); end
    tick(); tick();
    checks++; if (bus.ascii_wr_en !== 1'b0) begin errors++; $display("FAIL post_clear_wr_en got %0d want 0", bus.ascii_wr_en); end
  endtask

  task automatic test_back_to_back();
    bus.rx_data  = 8'h41;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_data  = 8'h42;
    checks++; if (bus.ascii_wr_en !== 1'b1 || bus.ascii_address !== 13'd0 || bus.ascii_data !== 8'h41)
      begin errors++; $display("FAIL ab_first got wr=%0d addr=%0d data=%0h want 1/0/41", bus.ascii_wr_en, bus.ascii_address, bus.ascii_data); end
    checks++; if (bus.cursor !== 13'd1) begin errors++; $display("FAIL ab_cursor1 got %0d want 1", bus.cursor); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL ab_ready got %0d want 1", bus.rx_ready); end
    tick();
    bus.rx_valid = 1'b0;
    checks++; if (bus.ascii_wr_en !== 1'b1 || bus.ascii_address !== 13'd1 || bus.ascii_data !== 8'h42)
      begin errors++; $display("FAIL ab_second got wr=%0d addr=%0d data=%0h want 1/1/42", bus.ascii_wr_en, bus.ascii_address, bus.ascii_data); end
    checks++; if (bus.cursor !== 13'd2) begin errors++; $display("FAIL ab_cursor2 got %0d want 2", bus.cursor); end
    tick();
    checks++; if (bus.ascii_wr_en !== 1'b0) begin errors++; $display("FAIL ab_idle_wr got %0d want 0", bus.ascii_wr_en); end
  endtask

  // 80 printable bytes on row 0, wrap, then the row-1 clear.
  task automatic test_line_wrap();
    int bad = 0;
    send(CH_CR);
    checks++; if (bus.ascii_wr_en !== 1'b0 || bus.cursor !== 13'd0)
      begin errors++; $display("FAIL cr got wr=%0d cursor=%0d want 0/0", bus.ascii_wr_en, bus.cursor); end
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      bus.rx_data = 8'h30 + 8'(i % 10);
      if (bus.rx_ready !== 1'b1) bad++;
      tick();
      if (bus.ascii_wr_en !== 1'b1 || bus.ascii_address !== 13'(i) || bus.ascii_data !== 8'h30 + 8'(i % 10)) begin
        if (bad == 0)
          $display("FAIL row_fill byte %0d got wr=%0d addr=%0d data=%0h", i, bus.ascii_wr_en, bus.ascii_address, bus.ascii_data);
        bad++;
      end
    end
    bus.rx_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL row_fill_bad got %0d want 0", bad); end
    checks++; if (bus.ascii_address !== 13'd79) begin errors++; $display("FAIL row_fill_last_addr got %0d want 79", bus.ascii_address); end
    checks++; if (bus.cursor !== 13'd80) begin errors++; $display("FAIL wrap_cursor got %0d want 80", bus.cursor); end
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL wrap_ready got %0d want 0", bus.rx_ready); end
    bad = 0;
    for (int j = 0; j < 80; j++) begin
      tick();
      if (bus.ascii_wr_en !== 1'b1 || bus.ascii_address !== 13'(80 + j) ||
          bus.ascii_data !== 8'h20 || bus.rx_ready !== (j == 79)) begin
        if (bad == 0)
          $display("FAIL line_clear cycle %0d got wr=%0d addr=%0d data=%0h rdy=%0d", j, bus.ascii_wr_en, bus.ascii_address, bus.ascii_data, bus.rx_ready);
        bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL line_clear_bad got %0d want 0", bad); end
    checks++; if (bus.cursor !== 13'd80) begin errors++; $display("FAIL line_clear_cursor got %0d want 80", bus.cursor); end
  endtask

  // Row 1: "xyz" then BS at col 3, CR, BS at col 0.
  task automatic test_backspace();
    send(8'h78); send(8'h79); send(8'h7A);
    checks++; if (bus.cursor !== 13'd83) begin errors++; $display("FAIL bs_setup_cursor got %0d want 83", bus.cursor); end
    send(CH_BS);
    checks++; if (bus.ascii_wr_en !== 1'b1 || bus.ascii_address !== 13'd82 || bus.ascii_data !== 8'h20)
      begin errors++; $display("FAIL bs_write got wr=%0d addr=%0d data=%0h want 1/82/20", bus.ascii_wr_en, bus.ascii_address, bus.ascii_data); end
    checks++; if (bus.cursor !== 13'd82) begin errors++; $display("FAIL bs_cursor got %0d want 82", bus.cursor); end
    send(CH_CR);
    send(CH_BS);
    checks++; if (bus.ascii_wr_en !== 1'b0) begin errors++; $display("FAIL bs_col0_wr got %0d want 0", bus.ascii_wr_en); end
    checks++; if (bus.cursor !== 13'd80) begin errors++; $display("FAIL bs_col0_cursor got %0d want 80", bus.cursor); end
  endtask

  // Walk to row 59 col 5, LF wraps to row 0 and clears 0..79.
  task automatic test_lf_wrap();
    int bad = 0;
    for (int k = 0; k < 58; k++) send(CH_LF);
    wait_ready(200);
    checks++; if (bus.cursor !== 13'd4720) begin errors++; $display("FAIL row59_cursor got %0d want 4720", bus.cursor); end
    for (int k = 0; k < 5; k++) send(8'h61);
    checks++; if (bus.ascii_address !== 13'd4724 || bus.cursor !== 13'd4725)
      begin errors++; $display("FAIL row59_col5 got addr=%0d cursor=%0d want 4724/4725", bus.ascii_address, bus.cursor); end
    send(CH_LF);
    checks++; if (bus.ascii_wr_en !== 1'b0 || bus.rx_ready !== 1'b0 || bus.cursor !== 13'd0)
      begin errors++; $display("FAIL lf_wrap got wr=%0d rdy=%0d cursor=%0d want 0/0/0", bus.ascii_wr_en, bus.rx_ready, bus.cursor); end
    for (int j = 0; j < 80; j++) begin
      tick();
      if (bus.ascii_wr_en !== 1'b1 || bus.ascii_address !== 13'(j) ||
          bus.ascii_data !== 8'h20 || bus.rx_ready !== (j == 79)) begin
        if (bad == 0)
          $display("FAIL lf_clear cycle %0d got wr=%0d addr=%0d data=%0h rdy=%0d", j, bus.ascii_wr_en, bus.ascii_address, bus.ascii_data, bus.rx_ready);
        bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL lf_clear_bad got %0d want 0", bad); end
    checks++; if (bus.cursor !== 13'd0) begin errors++; $display("FAIL lf_clear_cursor got %0d want 0", bus.cursor); end
  endtask

  task automatic test_tab_other();
    logic [12:0] exp_cur;
    send(8'h61); send(8'h62); send(8'h63);
    send(CH_TAB);
`ifdef CONSOLE_TAB_EN
    exp_cur = 13'd8;
`else
    exp_cur = 13'd3;
`endif
    checks++; if (bus.ascii_wr_en !== 1'b0) begin errors++; $display("FAIL tab_wr got %0d want 0", bus.ascii_wr_en); end
    checks++; if (bus.cursor !== exp_cur) begin errors++; $display("FAIL tab_cursor got %0d want %0d", bus.cursor, exp_cur); end
    send(8'h07);
    checks++; if (bus.ascii_wr_en !== 1'b0 || bus.cursor !== exp_cur || bus.rx_ready !== 1'b1)
      begin errors++; $display("FAIL other_byte got wr=%0d cursor=%0d rdy=%0d want 0/%0d/1", bus.ascii_wr_en, bus.cursor, bus.rx_ready, exp_cur); end
  endtask

  // FF starts a screen clear; reset mid-clear aborts and restarts it.
  task automatic test_ff_reset();
    int bad = 0;
    send(CH_FF);
    checks++; if (bus.rx_ready !== 1'b0 || bus.ascii_wr_en !== 1'b0)
      begin errors++; $display("FAIL ff_accept got rdy=%0d wr=%0d want 0/0", bus.rx_ready, bus.ascii_wr_en); end
    for (int j = 0; j < 100; j++) begin
      tick();
      if (bus.ascii_wr_en !== 1'b1 || bus.ascii_address !== 13'(j) || bus.ascii_data !== 8'h20) begin
        if (bad == 0)
          $display("FAIL ff_clear cycle %0d got wr=%0d addr=%0d data=%0h", j, bus.ascii_wr_en, bus.ascii_address, bus.ascii_data);
        bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ff_clear_bad got %0d want 0", bad); end
    rst_n = 1'b0;
    #2;
    checks++; if (bus.ascii_wr_en !== 1'b0 || bus.ascii_address !== 13'd0 || bus.ascii_data !== 8'h00 || bus.cursor !== 13'd0)
      begin errors++; $display("FAIL async_reset got wr=%0d addr=%0d data=%0h cursor=%0d want all 0",
                               bus.ascii_wr_en, bus.ascii_address, bus.ascii_data, bus.cursor); end
    test_reset();
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_back_to_back();
    test_line_wrap();
    test_backspace();
    test_lf_wrap();
    test_tab_other();
    test_ff_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_console_ctrl.md
# text_console_ctrl

Sequencer that turns a byte stream (UART receiver output) into writes on the character-RAM write port of the VGA text frame buffer. It tracks the text cursor, interprets control characters, and performs line and screen clears one cell per clock. It drives the RAM's `ascii_address`/`ascii_data`/`ascii_wr_en` port and the display's `cursor` input.

## Interface
- `COLS`, default 80: characters per row.
- `ROWS`, default 60: rows per screen; `COLS*ROWS` must be ≤ 8192.
- `BLANK`, default 8'h20: fill character used by clears and backspace.

Ports:
- `clk`, input, 1: the only clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx_data`, input, 8: incoming byte.
- `rx_valid`, input, 1: `rx_data` is valid.
- `rx_ready`, output, 1: block can accept a byte. A transfer happens on an edge with `rx_valid && rx_ready`.
- `ascii_address`, output, 13: character-RAM write address.
- `ascii_data`, output, 8: character-RAM write data.
- `ascii_wr_en`, output, 1: character-RAM write strobe, one write per cycle high.
- `cursor`, output, 13: linear cursor address, `row*COLS+col`.

## Operation
- State registers:
  - `col` ∈ [0,COLS-1] and `row` ∈ [0,ROWS-1].
  - `line_base = row*COLS`, maintained incrementally (add COLS, or reset to 0 on wrap). No multiplier.
- FSM states: `CLR_SCREEN`, `IDLE`, `CLR_LINE`. `rx_ready = (state==IDLE)`.
- `CLR_SCREEN`:
  - Writes BLANK to addresses 0..COLS*ROWS-1 in ascending order, one per cycle.
  - Then `col=row=0` and the FSM goes to `IDLE`.
  - This state is entered on reset release.
- `CLR_LINE`:
  - Writes BLANK to `line_base`..`line_base+COLS-1`, one per cycle.
  - Then the FSM goes to `IDLE`.
- Byte decoding in `IDLE` (on acceptance):
  - 0x20–0x7E printable: write the byte at `line_base+col`, then `col++`. If `col` was COLS-1, set `col=0`, advance `row`, and go to `CLR_LINE`.
  - 0x0D CR: `col=0`, no write.
  - 0x0A LF: `col=0`, advance `row`, go to `CLR_LINE`.
  - 0x08 BS: if `col>0`, `col--` and write BLANK at the new position. At `col==0`, no-op (no wrap to the previous row).
  - 0x0C FF: go to `CLR_SCREEN`; the cursor homes when the clear completes.
  - 0x09 TAB: see Configuration.
  - All other bytes: consumed and ignored.
- Row advance: `row==ROWS-1` wraps to 0 (`line_base=0`). There is no scrolling; the freshly entered row is cleared instead.

## Timing
- Reset values:
  - `rx_ready=0`, `ascii_wr_en=0`, `ascii_address=0`, `ascii_data=0`, `cursor=0`.
  - State = `CLR_SCREEN` with the clear counter at 0.
- All outputs are registered.
- Write latency: a byte accepted at edge N produces `ascii_wr_en=1` with address and data valid during cycle N+1 (visible at edge N+1 to the RAM).
- `cursor` updates at edge N+1, at the same time as the write.
- Throughput: printable bytes can be accepted every cycle (back-to-back) while `col` stays below COLS-1.
- `rx_ready` deasserts at the edge where a wrap, LF or FF is accepted, and stays low for exactly:
  - COLS cycles for `CLR_LINE`;
  - COLS*ROWS cycles for `CLR_SCREEN`.
  - It reasserts the cycle after the last clear write.
- During a clear, the first write occurs in the first cycle after entry and `cursor` shows the post-operation position. `ascii_wr_en` is high in every clear cycle.
- Reset cycles:
  - Post-reset clear is 4800 cycles at the defaults; first `rx_ready=1` appears 4800 cycles after `rst_n` rises.
  - `rst_n` asserted mid-clear or mid-write aborts immediately. Outputs go to reset values asynchronously, and the full screen clear restarts on release.
- `ascii_wr_en` is low in `IDLE` whenever no printable byte or BS-with-write was accepted on the previous edge.

## Configuration
- `CONSOLE_TAB_EN` defined: 0x09 sets `col` to the next multiple of 8, with no RAM write.
  - If that value is ≥ COLS, it behaves as a wrap: `col=0`, advance `row`, go to `CLR_LINE`.
- `CONSOLE_TAB_EN` undefined: 0x09 falls into "other bytes" (consumed, ignored).

## Structure
- Shared package `console_pkg`:
  - FSM state enum (`CLR_SCREEN`, `IDLE`, `CLR_LINE`).
  - Control-character constants (CR, LF, BS, FF, TAB).
  - Printable range bounds.
  - Address width constant (13).
- Natural sub-module: `console_cursor`. It holds `col`, `row` and `line_base`, with inputs inc/dec/home/newline/tab. It outputs `col`, `row`, `line_base`, an at-last-col flag and the `cursor` address.
- The FSM and clear counter live in the top module.

## Test plan
- Reset release, `rx_valid=0`:
  - Exactly 4800 writes of 0x20 to addresses 0..4799.
  - Then `rx_ready=1` and `cursor=0`.
- Send "AB" back-to-back after the clear:
  - Writes (0,0x41) then (1,0x42) on consecutive cycles.
  - `cursor` steps 1 then 2.
- Type 80 printable bytes on row 0:
  - The 80th writes address 79.
  - Then 80 BLANK writes to 80..159, with `rx_ready` low 80 cycles.
  - `cursor=80`.
- At `row=59`, `col=5`, send 0x0A:
  - BLANK writes to 0..79.
  - `cursor=0`.
- At `col=3`, send 0x08 then 0x08 at `col=0`:
  - First: write BLANK at `line_base+2`, `cursor` decremented.
  - Second: no write, `cursor` unchanged.
- Assert `rst_n=0` in the middle of a 0x0C clear:
  - Outputs zero immediately.
  - After release, the full 4800-cycle clear restarts from address 0.
  - With `CONSOLE_TAB_EN`, 0x09 at `col=3` sets `cursor` to `line_base+8` with no write.
